// File: rtl/core_add_sub_arbiter_pkg.sv
// Purpose: shared widths, width helpers and the operand payload struct for the
//          shared add/sub datapath and its requester arbitration.
// Contents: te_size()/mant_size() width helpers, default ADDSUB_* widths,
//           addsub_req_t (te1, te2, mant1, mant2, opp_sign, tag).
package core_add_sub_arbiter_pkg;

  // Total-exponent width for an N-bit posit (regime + exponent range, signed).
  function automatic int unsigned te_size(input int unsigned n);
    return $clog2(n) + 2;
  endfunction

  // Mantissa width including the hidden one at the MSB.
  function automatic int unsigned mant_size(input int unsigned n);
    return n - 2;
  endfunction

  localparam int unsigned ADDSUB_N      = 16;
  localparam int unsigned ADDSUB_TE_W   = te_size(ADDSUB_N);
  localparam int unsigned ADDSUB_MANT_W = mant_size(ADDSUB_N);
  localparam int unsigned ADDSUB_TAG_W  = 4;

  // Operand bundle latched into the operand stage.
  typedef struct packed {
    logic [ADDSUB_TE_W-1:0]   te1;
    logic [ADDSUB_TE_W-1:0]   te2;
    logic [ADDSUB_MANT_W-1:0] mant1;
    logic [ADDSUB_MANT_W-1:0] mant2;
    logic                     opp_sign;
    logic [ADDSUB_TAG_W-1:0]  tag;
  } addsub_req_t;

endpackage

// File: rtl/core_add_sub.sv
// Purpose: combinational posit mantissa add/subtract with normalisation.
//   mant1 is the larger-magnitude operand; mant2 is aligned to it by te1-te2,
//   added or subtracted, then left-normalised so the result MSB is the hidden one.
// Ports: te1_in/te2_in total exponents, mant1_in/mant2_in mantissas (hidden one
//   at MSB), have_opposite_sign selects subtract, mant_out normalised 2*MANT_SIZE
//   mantissa, te_out result exponent (two's complement, wraps).
module core_add_sub
  import core_add_sub_arbiter_pkg::*;
#(
  parameter int unsigned N = ADDSUB_N,
  localparam int unsigned TE_SIZE   = te_size(N),
  localparam int unsigned MANT_SIZE = mant_size(N)
) (
  input  logic [TE_SIZE-1:0]     te1_in,
  input  logic [TE_SIZE-1:0]     te2_in,
  input  logic [MANT_SIZE-1:0]   mant1_in,
  input  logic [MANT_SIZE-1:0]   mant2_in,
  input  logic                   have_opposite_sign,
  output logic [2*MANT_SIZE-1:0] mant_out,
  output logic [TE_SIZE-1:0]     te_out
);

  // One guard bit above the operands absorbs the carry of an addition.
  localparam int unsigned SUM_W = 2 * MANT_SIZE + 1;
  localparam int unsigned OUT_W = 2 * MANT_SIZE;
  localparam int unsigned LZ_W  = $clog2(SUM_W + 1);

  logic [TE_SIZE-1:0] te_diff;
  logic [SUM_W-1:0]   mant1_ext;
  logic [SUM_W-1:0]   mant2_ext;
  logic [SUM_W-1:0]   mant2_shf;
  logic [SUM_W-1:0]   sum;
  logic [LZ_W-1:0]    lz;
  logic               found;

  assign te_diff   = te1_in - te2_in;
  assign mant1_ext = {1'b0, mant1_in, {MANT_SIZE{1'b0}}};
  assign mant2_ext = {1'b0, mant2_in, {MANT_SIZE{1'b0}}};
  assign mant2_shf = mant2_ext >> te_diff;
  assign sum       = have_opposite_sign ? (mant1_ext - mant2_shf) : (mant1_ext + mant2_shf);

  // Leading-zero count over the full sum; an all-zero sum reports SUM_W.
  always_comb begin
    lz    = LZ_W'(SUM_W);
    found = 1'b0;
    for (int i = SUM_W - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz    = LZ_W'(SUM_W - 1 - i);
      end
    end
  end

  // Normalised sum drops the guard position; exponent gains one for the guard.
  assign mant_out = OUT_W'((sum << lz) >> 1);
  assign te_out   = te1_in + TE_SIZE'(1) - TE_SIZE'(lz);

endmodule

// File: rtl/core_add_sub_arbiter_rr_arbiter.sv
// Purpose: round-robin arbiter; picks the first asserted request scanning
//   upward from ptr, modulo NREQ. Pointer update is left to the caller.
// Ports: req request vector, ptr scan start, grant one-hot (or zero),
//   idx index of the granted request, any set when some request is granted.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(ptr) + 32'(k)) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/core_add_sub_arbiter.sv
// Purpose: shares one core_add_sub between NREQ requesters. Round-robin grant
//   into an operand stage (S0), core_add_sub evaluated on S0, result stage (S1)
//   drives the outputs. Results carry the requester index and opaque tag.
// Ports: clk, rst_n (async active-low), flush (sync clear of stage valids),
//   req_valid/req_ready per-requester handshake, req_te1/te2/mant1/mant2/
//   opp_sign/tag packed per requester (requester i at slice i),
//   out_valid/out_ready result handshake, out_mant/out_te result,
//   out_id originating requester, out_tag originating tag.
module core_add_sub_arbiter
  import core_add_sub_arbiter_pkg::*;
#(
  parameter int unsigned N     = ADDSUB_N,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned TAG_W = ADDSUB_TAG_W,
  localparam int unsigned TE_SIZE   = te_size(N),
  localparam int unsigned MANT_SIZE = mant_size(N),
  localparam int unsigned IDX_W     = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*TE_SIZE-1:0]      req_te1,
  input  logic [NREQ*TE_SIZE-1:0]      req_te2,
  input  logic [NREQ*MANT_SIZE-1:0]    req_mant1,
  input  logic [NREQ*MANT_SIZE-1:0]    req_mant2,
  input  logic [NREQ-1:0]              req_opp_sign,
  input  logic [NREQ*TAG_W-1:0]        req_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*MANT_SIZE-1:0]       out_mant,
  output logic [TE_SIZE-1:0]           out_te,
  output logic [IDX_W-1:0]             out_id,
  output logic [TAG_W-1:0]             out_tag
);

  addsub_req_t        s0_q;
  addsub_req_t        s0_d;
  logic               s0_valid;
  logic               s1_valid;
  logic [IDX_W-1:0]   s0_id;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gidx;
  logic [NREQ-1:0]    grant;
  logic               any_req;
  logic               s1_adv;
  logic               s0_free;
  logic               accept;
  logic [2*MANT_SIZE-1:0] core_mant;
  logic [TE_SIZE-1:0]     core_te;

  // Pipeline advance conditions.
  assign s1_adv  = s0_valid && (!s1_valid || out_ready);
  assign s0_free = !s0_valid || s1_adv;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_req)
  );

  // Ready is suppressed in reset and during flush so no handshake is lost.
  assign accept    = any_req && s0_free && !flush && rst_n;
  assign req_ready = accept ? grant : '0;
  assign out_valid = s1_valid;

  // Steer the granted requester's payload into the S0 bundle.
  always_comb begin
    s0_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        s0_d.te1      = req_te1[i*TE_SIZE +: TE_SIZE];
        s0_d.te2      = req_te2[i*TE_SIZE +: TE_SIZE];
        s0_d.mant1    = req_mant1[i*MANT_SIZE +: MANT_SIZE];
        s0_d.mant2    = req_mant2[i*MANT_SIZE +: MANT_SIZE];
        s0_d.opp_sign = req_opp_sign[i];
        s0_d.tag      = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Stage valids; flush wins over every advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else if (flush) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s0_valid <= accept || (s0_valid && !s1_adv);
      s1_valid <= s1_adv || (s1_valid && !out_ready);
    end
  end

  // Operand stage and round-robin pointer, updated only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= '0;
      s0_id  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      s0_q   <= s0_d;
      s0_id  <= gidx;
      rr_ptr <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
    end
  end

  core_add_sub #(.N(N)) u_core_add_sub (
    .te1_in             (s0_q.te1),
    .te2_in             (s0_q.te2),
    .mant1_in           (s0_q.mant1),
    .mant2_in           (s0_q.mant2),
    .have_opposite_sign (s0_q.opp_sign),
    .mant_out           (core_mant),
    .te_out             (core_te)
  );

  // Result stage; held while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mant <= '0;
      out_te   <= '0;
      out_id   <= '0;
      out_tag  <= '0;
    end else if (s1_adv && !flush) begin
      out_mant <= core_mant;
      out_te   <= core_te;
      out_id   <= s0_id;
      out_tag  <= s0_q.tag;
    end
  end

endmodule

// File: tb/tb_core_add_sub_arbiter.sv
// Bench for core_add_sub_arbiter with NREQ=2, N=16 (TE 6 bits, mantissa 14 bits).
module tb_core_add_sub_arbiter;

  localparam int unsigned N     = 16;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned TE    = 6;
  localparam int unsigned MS    = 14;
  localparam int unsigned OW    = 28;
  localparam logic [OW-1:0] ONE_0 = 28'h8000000;
  localparam logic [OW-1:0] ONE_5 = 28'hC000000;
  localparam logic [MS-1:0] M_ONE = 14'h2000;

  typedef struct packed {
    logic [OW-1:0]    mant;
    logic [TE-1:0]    te;
    logic             id;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*TE-1:0]    req_te1;
  logic [NREQ*TE-1:0]    req_te2;
  logic [NREQ*MS-1:0]    req_mant1;
  logic [NREQ*MS-1:0]    req_mant2;
  logic [NREQ-1:0]       req_opp_sign;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [OW-1:0]         out_mant;
  logic [TE-1:0]         out_te;
  logic [0:0]            out_id;
  logic [TAG_W-1:0]      out_tag;

  logic [TE-1:0]    cur_te1 [NREQ];
  logic [TE-1:0]    cur_te2 [NREQ];
  logic [MS-1:0]    cur_m1  [NREQ];
  logic [MS-1:0]    cur_m2  [NREQ];
  logic             cur_opp [NREQ];
  logic [TAG_W-1:0] cur_tag [NREQ];

  exp_t sb[$];
  int   grant_log[$];
  int   out_log[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  core_add_sub_arbiter #(.N(N), .NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_te1      (req_te1),
    .req_te2      (req_te2),
    .req_mant1    (req_mant1),
    .req_mant2    (req_mant2),
    .req_opp_sign (req_opp_sign),
    .req_tag      (req_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mant     (out_mant),
    .out_te       (out_te),
    .out_id       (out_id),
    .out_tag      (out_tag)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_te1[i*TE +: TE]         = cur_te1[i];
      req_te2[i*TE +: TE]         = cur_te2[i];
      req_mant1[i*MS +: MS]       = cur_m1[i];
      req_mant2[i*MS +: MS]       = cur_m2[i];
      req_opp_sign[i]             = cur_opp[i];
      req_tag[i*TAG_W +: TAG_W]   = cur_tag[i];
    end
  end

  // Reference arithmetic: align, add/sub at double width, normalise by shifting.
  function automatic exp_t model(input int id, input logic [TE-1:0] te1, input logic [TE-1:0] te2,
                                 input logic [MS-1:0] m1, input logic [MS-1:0] m2,
                                 input logic opp, input logic [TAG_W-1:0] tag);
    exp_t r;
    logic [28:0] a;
    logic [28:0] b;
    logic [28:0] s;
    logic [TE-1:0] d;
    int lz;
    d = te1 - te2;
    a = {1'b0, m1, 14'd0};
    b = {1'b0, m2, 14'd0} >> d;
    s = opp ? (a - b) : (a + b);
    lz = 0;
    while (lz < 29 && s[28] == 1'b0) begin
      s  = s << 1;
      lz = lz + 1;
    end
    r.mant = s[28:1];
    r.te   = te1 + 6'd1 - 6'(lz);
    r.id   = 1'(id);
    r.tag  = tag;
    return r;
  endfunction

  // Scoreboard: push on request handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (!rst_n) begin
      sb.delete();
    end else begin
      checks++;
      if ($countones(req_ready) > 1) begin
        failures++;
        $display("FAIL onehot_ready: req_ready=%b, required at most one bit", req_ready);
      end
      checks++;
      if ((req_ready & ~req_valid) != '0) begin
        failures++;
        $display("FAIL ready_without_valid: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      if (out_valid && out_ready) begin
        out_log.push_back(int'(out_id));
        got = '{mant: out_mant, te: out_te, id: out_id[0], tag: out_tag};
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL result: got mant=%h te=%h id=%0d tag=%h, required mant=%h te=%h id=%0d tag=%h",
                     got.mant, got.te, got.id, got.tag, e.mant, e.te, e.id, e.tag);
          end
        end
      end
      if (flush) sb.delete();
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(model(i, cur_te1[i], cur_te2[i], cur_m1[i], cur_m2[i], cur_opp[i], cur_tag[i]));
          grant_log.push_back(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_load(input int i);
    int unsigned d;
    logic [MS-1:0] t;
    d          = $urandom_range(0, 13);
    cur_te1[i] = 6'($urandom_range(13, 63));
    cur_te2[i] = cur_te1[i] - 6'(d);
    cur_m1[i]  = {1'b1, 13'($urandom)};
    cur_m2[i]  = {1'b1, 13'($urandom)};
    cur_opp[i] = 1'($urandom_range(0, 1));
    cur_tag[i] = 4'($urandom);
    if (d == 0 && cur_m2[i] > cur_m1[i]) begin
      t         = cur_m1[i];
      cur_m1[i] = cur_m2[i];
      cur_m2[i] = t;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < NREQ; i++) rand_load(i);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_mant !== '0 || out_te !== '0 || out_id !== '0 || out_tag !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b mant=%h te=%h id=%b tag=%h, required all zero",
               out_valid, out_mant, out_te, out_id, out_tag);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: req_ready=%b, required 00", req_ready);
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_directed(input int i, input logic [TE-1:0] te1, input logic [TE-1:0] te2,
                              input logic opp, input logic [TAG_W-1:0] tag,
                              input logic [TE-1:0] exp_te, input logic [OW-1:0] exp_mant, input string nm);
    cur_te1[i] = te1; cur_te2[i] = te2; cur_m1[i] = M_ONE; cur_m2[i] = M_ONE;
    cur_opp[i] = opp; cur_tag[i] = tag;
    req_valid = '0;
    req_valid[i] = 1'b1;
    #1;
    checks++;
    if (req_ready !== req_valid) begin
      failures++;
      $display("FAIL %s_grant: req_ready=%b, required %b", nm, req_ready, req_valid);
    end
    tick();
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: out_valid=%b one edge after accept, required 0", nm, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_te !== exp_te || out_mant !== exp_mant ||
        out_id !== 1'(i) || out_tag !== tag) begin
      failures++;
      $display("FAIL %s_result: valid=%b te=%h mant=%h id=%0d tag=%h, required 1 %h %h %0d %h",
               nm, out_valid, out_te, out_mant, out_id, out_tag, exp_te, exp_mant, i, tag);
    end
    tick();
  endtask

  task automatic test_single();
    run_directed(0, 6'd0, 6'd0, 1'b0, 4'd5, 6'd1, ONE_0, "single");
  endtask

  task automatic test_subtract();
    run_directed(1, 6'd2, 6'd0, 1'b1, 4'd3, 6'd1, ONE_5, "subtract");
  endtask

  task automatic test_contention();
    int gaps;
    grant_log.delete();
    out_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_load(i);
    req_valid = 2'b11;
    gaps = 0;
    for (int j = 0; j < 6; j++) begin
      logic [NREQ-1:0] rdy;
      #1;
      rdy = req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) if (rdy[i]) rand_load(i);
      if (j >= 1 && out_valid !== 1'b1) gaps++;
    end
    req_valid = 2'b00;
    tick();
    if (out_valid !== 1'b1) gaps++;
    tick();
    tick();
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL contention_gaps: %0d bubble cycles, required 0", gaps);
    end
    checks++;
    if (grant_log.size() != 6) begin
      failures++;
      $display("FAIL contention_count: %0d grants, required 6", grant_log.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (grant_log[j] != (j % 2)) begin
          failures++;
          $display("FAIL contention_order: grant %0d went to r%0d, required r%0d", j, grant_log[j], j % 2);
        end
      end
    end
    checks++;
    if (out_log.size() != 6 || out_log != grant_log) begin
      failures++;
      $display("FAIL contention_ids: %0d outputs, id order differs from grant order", out_log.size());
    end
  endtask

  task automatic fill_stalled();
    out_ready = 1'b0;
    rand_load(0);
    req_valid = 2'b01;
    tick();
    rand_load(1);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL fill_refill: req_ready=%b, required 10", req_ready);
    end
    tick();
    rand_load(0);
    req_valid = 2'b11;
    #1;
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] m0; logic [TE-1:0] t0; logic [TAG_W-1:0] g0;
    int n0;
    fill_stalled();
    checks++;
    if (req_ready !== 2'b00 || out_valid !== 1'b1 || out_id !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: req_ready=%b out_valid=%b out_id=%0d, required 00 1 0", req_ready, out_valid, out_id);
    end
    m0 = out_mant; t0 = out_te; g0 = out_tag;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (out_mant !== m0 || out_te !== t0 || out_tag !== g0 || out_valid !== 1'b1 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d mant=%h te=%h tag=%h valid=%b ready=%b, required %h %h %h 1 00",
                 j, out_mant, out_te, out_tag, out_valid, req_ready, m0, t0, g0);
      end
    end
    n0 = out_log.size();
    req_valid = 2'b00;
    out_ready = 1'b1;
    for (int j = 0; j < 10 && out_valid; j++) tick();
    checks++;
    if (out_log.size() - n0 != 2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: %0d results drained, out_valid=%b, required 2 and 0", out_log.size() - n0, out_valid);
    end
  endtask

  task automatic test_flush();
    int w;
    fill_stalled();
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL flush_ready: req_ready=%b during flush, required 00", req_ready);
    end
    tick();
    flush = 1'b0;
    req_valid = 2'b00;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: out_valid=%b after flush, required 0", out_valid);
    end
    out_ready = 1'b1;
    rand_load(0);
    cur_tag[0] = 4'd9;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    w = 0;
    while (!out_valid && w < 5) begin
      tick();
      w++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd9 || out_id !== 1'b0) begin
      failures++;
      $display("FAIL flush_next: valid=%b tag=%h id=%0d, required 1 9 0", out_valid, out_tag, out_id);
    end
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_load(i);
    req_valid = 2'b11;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL areset_now: out_valid=%b req_ready=%b, required 0 00", out_valid, req_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL areset_first_grant: req_ready=%b, required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      cur_te1[i] = '0; cur_te2[i] = '0; cur_m1[i] = '0; cur_m2[i] = '0; cur_opp[i] = 1'b0; cur_tag[i] = '0;
    end
    test_reset();
    test_single();
    test_subtract();
    test_contention();
    test_backpressure();
    test_flush();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d results outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
